// File: rtl/awg_wave_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : awg_wave_sched
// Description : Table-driven AWG waveform scheduler; every mode change and
//               stop is aligned to a phase-counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module awg_wave_sched #(
    parameter int N_STEPS = 4,
    parameter int IDX_W   = 2,
    parameter int DWELL_W = 24,
    parameter int MODE_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [MODE_W-1:0]  cfg_mode,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [IDX_W-1:0]   cfg_last,
    input  logic               cfg_loop,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    input  logic               cnt_wrap,
    output logic [3:0]         wave_en,
    output logic [MODE_W-1:0]  wave_sel,
    output logic [IDX_W-1:0]   step_idx,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PEND  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [MODE_W-1:0]  C_MODE_OFF  = MODE_W'(3);
    localparam logic [DWELL_W-1:0] C_DWELL_ONE = DWELL_W'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [MODE_W-1:0]  r_mode_tab  [N_STEPS];
    logic [DWELL_W-1:0] r_dwell_tab [N_STEPS];
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [IDX_W-1:0]   r_last;
    logic               r_loop;
    logic [IDX_W-1:0]   r_step_idx;
    logic [3:0]         r_wave_en;
    logic [MODE_W-1:0]  r_wave_sel;
    logic               r_done;
    logic               r_cfg_err;

    logic               w_is_last;
    logic               w_seq_end;
    logic               w_start;
    logic               w_load;
    logic               w_finish;
    logic [IDX_W-1:0]   w_load_idx;
    logic [MODE_W-1:0]  w_load_mode;
    logic [DWELL_W-1:0] w_load_dwell;

    function automatic logic [3:0] f_onehot(input logic [MODE_W-1:0] mode);
        logic [3:0] oh;
        oh = 4'b0000;
        if (mode == MODE_W'(0))      oh = 4'b0001;
        else if (mode == MODE_W'(1)) oh = 4'b0010;
        else if (mode == MODE_W'(2)) oh = 4'b0100;
        return oh;
    endfunction

    assign w_is_last = (r_step_idx == r_last);
    assign w_seq_end = w_is_last && !r_loop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // stop always wins over a coincident wrap
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) w_state_nxt = S_ARM;
            end
            S_ARM: begin
                if (stop)          w_state_nxt = S_IDLE;
                else if (cnt_wrap) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (stop)                           w_state_nxt = S_DRAIN;
                else if (r_dwell_cnt <= C_DWELL_ONE) w_state_nxt = S_PEND;
            end
            S_PEND: begin
                if (stop)          w_state_nxt = S_DRAIN;
                else if (cnt_wrap) w_state_nxt = w_seq_end ? S_IDLE : S_RUN;
            end
            S_DRAIN: begin
                if (cnt_wrap) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start    = 1'b0;
        w_load     = 1'b0;
        w_finish   = 1'b0;
        w_load_idx = r_step_idx;
        case (r_state)
            S_IDLE: begin
                w_start = start && !stop;
            end
            S_ARM: begin
                if (stop)          w_finish = 1'b1;
                else if (cnt_wrap) w_load   = 1'b1;
            end
            S_PEND: begin
                if (!stop && cnt_wrap) begin
                    if (w_seq_end) begin
                        w_finish = 1'b1;
                    end else begin
                        w_load     = 1'b1;
                        w_load_idx = w_is_last ? '0 : r_step_idx + IDX_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_wrap) w_finish = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_load_mode  = r_mode_tab[w_load_idx];
    assign w_load_dwell = r_dwell_tab[w_load_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STEPS; i++) begin
                r_mode_tab[i]  <= C_MODE_OFF;
                r_dwell_tab[i] <= C_DWELL_ONE;
            end
        end else if (cfg_we && (r_state == S_IDLE)) begin
            r_mode_tab[cfg_addr]  <= cfg_mode;
            r_dwell_tab[cfg_addr] <= cfg_dwell;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell_cnt <= '0;
            r_last      <= '0;
            r_loop      <= 1'b0;
            r_step_idx  <= '0;
            r_wave_en   <= 4'b0000;
            r_wave_sel  <= C_MODE_OFF;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_done    <= w_finish;
            r_cfg_err <= cfg_we && (r_state != S_IDLE);
            if (w_start) begin
                r_last     <= cfg_last;
                r_loop     <= cfg_loop;
                r_step_idx <= '0;
            end
            // a zero dwell is promoted to one cycle so RUN always exits
            if (w_load) begin
                r_step_idx  <= w_load_idx;
                r_wave_sel  <= w_load_mode;
                r_wave_en   <= f_onehot(w_load_mode);
                r_dwell_cnt <= (w_load_dwell == '0) ? C_DWELL_ONE : w_load_dwell;
            end else if (r_state == S_RUN) begin
                r_dwell_cnt <= r_dwell_cnt - C_DWELL_ONE;
            end
            if (w_finish) begin
                r_wave_en  <= 4'b0000;
                r_wave_sel <= C_MODE_OFF;
            end
        end
    end

    assign wave_en  = r_wave_en;
    assign wave_sel = r_wave_sel;
    assign step_idx = r_step_idx;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_awg_wave_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_awg_wave_sched
// Description : Scoreboard bench for awg_wave_sched with a fixed 8-cycle wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_awg_wave_sched;

    localparam int N_STEPS = 4;
    localparam int IDX_W   = 2;
    localparam int DWELL_W = 24;
    localparam int MODE_W  = 2;
    localparam int PER     = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [IDX_W-1:0]   cfg_addr = '0;
    logic [MODE_W-1:0]  cfg_mode = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic [IDX_W-1:0]   cfg_last = '0;
    logic               cfg_loop = 1'b0;
    logic               cfg_err;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               cnt_wrap = 1'b0;
    logic [3:0]         wave_en;
    logic [MODE_W-1:0]  wave_sel;
    logic [IDX_W-1:0]   step_idx;
    logic               busy;
    logic               done;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int                at;
        logic [3:0]        en;
        logic [MODE_W-1:0] sel;
        int                idx;
        logic              dn;
        logic              bz;
    } exp_t;

    exp_t q[$];
    int   sh_mode  [N_STEPS];
    int   sh_dwell [N_STEPS];

    awg_wave_sched #(
        .N_STEPS (N_STEPS),
        .IDX_W   (IDX_W),
        .DWELL_W (DWELL_W),
        .MODE_W  (MODE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_mode  (cfg_mode),
        .cfg_dwell (cfg_dwell),
        .cfg_last  (cfg_last),
        .cfg_loop  (cfg_loop),
        .cfg_err   (cfg_err),
        .start     (start),
        .stop      (stop),
        .cnt_wrap  (cnt_wrap),
        .wave_en   (wave_en),
        .wave_sel  (wave_sel),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // edge number e carries a wrap whenever e is a multiple of PER
    always @(posedge clk) begin
        #1;
        cnt_wrap = (((cyc + 1) % PER) == 0);
    end

    function automatic logic [3:0] exp_en(input int m);
        case (m)
            0:       return 4'b0001;
            1:       return 4'b0010;
            2:       return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int next_wrap_after(input int t);
        return (t / PER + 1) * PER;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) tick();
    endtask

    task automatic push_exp(input int at, input logic [3:0] en, input int sel,
                            input int idx, input logic dn, input logic bz);
        exp_t e;
        e.at  = at;
        e.en  = en;
        e.sel = MODE_W'(sel);
        e.idx = idx;
        e.dn  = dn;
        e.bz  = bz;
        q.push_back(e);
    endtask

    task automatic shadow_reset();
        for (int i = 0; i < N_STEPS; i++) begin
            sh_mode[i]  = 3;
            sh_dwell[i] = 1;
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        logic dn_exp;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) continue;
            dn_exp = 1'b0;
            checks++;
            if (wave_en !== exp_en(int'(wave_sel))) begin
                errors++;
                $display("FAIL onehot_inv edge %0d: wave_en=%b wave_sel=%0d, required wave_en=%b",
                         cyc, wave_en, wave_sel, exp_en(int'(wave_sel)));
            end
            while (q.size() > 0 && q[0].at < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL sched_missed: entry for edge %0d not observed (now %0d)", e.at, cyc);
            end
            if (q.size() > 0 && q[0].at == cyc) begin
                e = q.pop_front();
                checks++;
                dn_exp = e.dn;
                if (wave_en !== e.en || wave_sel !== e.sel || done !== e.dn || busy !== e.bz ||
                    (e.idx >= 0 && step_idx !== IDX_W'(e.idx))) begin
                    errors++;
                    $display("FAIL sched_out edge %0d: en=%b sel=%0d idx=%0d done=%b busy=%b, required en=%b sel=%0d idx=%0d done=%b busy=%b",
                             cyc, wave_en, wave_sel, step_idx, done, busy, e.en, e.sel, e.idx, e.dn, e.bz);
                end
            end
            if (done === 1'b1 && !dn_exp) begin
                checks++;
                errors++;
                $display("FAIL done_spurious edge %0d: done=1, required 0", cyc);
            end
        end
    endtask

    task automatic drain_q();
        for (int i = 0; i < 600 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries left, required 0", q.size());
            q.delete();
        end
        tick();
    endtask

    task automatic cfg_write(input int a, input int m, input int d);
        cfg_addr  = IDX_W'(a);
        cfg_mode  = MODE_W'(m);
        cfg_dwell = DWELL_W'(d);
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
        sh_mode[a]  = m;
        sh_dwell[a] = d;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_write_err: cfg_err=%b, required 0", cfg_err);
        end
    endtask

    task automatic do_start(input int last, input bit loop, output int s);
        cfg_last = IDX_W'(last);
        cfg_loop = loop;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        s        = cyc;
    endtask

    // Expected playback from the shadow table given the edge that sampled start.
    task automatic expect_steps(input int s, input int last, input bit loop,
                                input int nsteps, output int t_last);
        int t, tn, idx, m, eff;
        logic [3:0] p_en;
        int p_sel, p_idx;
        t = next_wrap_after(s);
        idx = 0;
        t_last = t;
        p_en = 4'b0000; p_sel = 3; p_idx = 0;
        for (int k = 0; k < nsteps; k++) begin
            m   = sh_mode[idx];
            eff = (sh_dwell[idx] == 0) ? 1 : sh_dwell[idx];
            if (k > 0) push_exp(t - 1, p_en, p_sel, p_idx, 1'b0, 1'b1);
            push_exp(t, exp_en(m), m, idx, 1'b0, 1'b1);
            t_last = t;
            tn = next_wrap_after(t + eff);
            p_en = exp_en(m); p_sel = m; p_idx = idx;
            if (idx == last) begin
                if (!loop) begin
                    push_exp(tn - 1, p_en, p_sel, p_idx, 1'b0, 1'b1);
                    push_exp(tn, 4'b0000, 3, -1, 1'b1, 1'b0);
                    push_exp(tn + 1, 4'b0000, 3, -1, 1'b0, 1'b0);
                    break;
                end
                idx = 0;
            end else begin
                idx = (idx + 1) % N_STEPS;
            end
            t = tn;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (wave_en !== 4'b0000 || wave_sel !== 2'd3 || step_idx !== '0 || busy !== 1'b0 ||
            done !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: en=%b sel=%0d idx=%0d busy=%b done=%b err=%b, required 0000/3/0/0/0/0",
                     wave_en, wave_sel, step_idx, busy, done, cfg_err);
        end
        #3 rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (wave_en !== 4'b0000 || wave_sel !== 2'd3 || step_idx !== '0 || busy !== 1'b0 ||
            done !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: en=%b sel=%0d idx=%0d busy=%b done=%b err=%b, required 0000/3/0/0/0/0",
                     wave_en, wave_sel, step_idx, busy, done, cfg_err);
        end
    endtask

    task automatic test_one_shot();
        int s, tl;
        cfg_write(0, 0, 10);
        cfg_write(1, 1, 5);
        do_start(1, 1'b0, s);
        expect_steps(s, 1, 1'b0, 2, tl);
        drain_q();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL one_shot_busy: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_loop_stop();
        int s, t5, td;
        do_start(1, 1'b1, s);
        expect_steps(s, 1, 1'b1, 6, t5);
        wait_until(t5 + 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        td = next_wrap_after(t5 + 2);
        push_exp(td - 1, 4'b0010, 1, 1, 1'b0, 1'b1);
        push_exp(td, 4'b0000, 3, -1, 1'b1, 1'b0);
        push_exp(td + 1, 4'b0000, 3, -1, 1'b0, 1'b0);
        drain_q();
    endtask

    task automatic test_busy_write();
        int s, tl;
        do_start(1, 1'b0, s);
        expect_steps(s, 1, 1'b0, 2, tl);
        cfg_addr  = '0;
        cfg_mode  = 2'd2;
        cfg_dwell = DWELL_W'(3);
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL busy_write_err: cfg_err=%b, required 1", cfg_err);
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL busy_write_pulse: cfg_err=%b, required 0", cfg_err);
        end
        drain_q();
    endtask

    task automatic test_dwell_zero();
        int s, tl;
        cfg_write(0, 3, 0);
        do_start(1, 1'b0, s);
        expect_steps(s, 1, 1'b0, 2, tl);
        drain_q();
    endtask

    task automatic test_single_step();
        int s, tl;
        cfg_write(0, 2, 4);
        do_start(0, 1'b0, s);
        expect_steps(s, 0, 1'b0, 1, tl);
        drain_q();
    endtask

    task automatic test_stop_wrap_pend();
        int s, t0, w, td;
        cfg_write(0, 0, 3);
        cfg_write(1, 1, 3);
        do_start(1, 1'b1, s);
        expect_steps(s, 1, 1'b1, 1, t0);
        w  = next_wrap_after(t0 + 3);
        td = next_wrap_after(w);
        push_exp(w, 4'b0001, 0, 0, 1'b0, 1'b1);
        push_exp(td - 1, 4'b0001, 0, 0, 1'b0, 1'b1);
        push_exp(td, 4'b0000, 3, -1, 1'b1, 1'b0);
        push_exp(td + 1, 4'b0000, 3, -1, 1'b0, 1'b0);
        wait_until(w - 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain_q();
    endtask

    task automatic test_arm_stop();
        int s;
        do_start(1, 1'b0, s);
        push_exp(s, 4'b0000, 3, 0, 1'b0, 1'b1);
        push_exp(s + 1, 4'b0000, 3, 0, 1'b1, 1'b0);
        push_exp(s + 2, 4'b0000, 3, 0, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain_q();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_async_reset();
        int s, t0, tl;
        cfg_write(0, 0, 10);
        cfg_write(1, 1, 5);
        do_start(1, 1'b0, s);
        expect_steps(s, 1, 1'b0, 1, t0);
        wait_until(t0 + 2);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (wave_en !== 4'b0000 || wave_sel !== 2'd3 || step_idx !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: en=%b sel=%0d idx=%0d busy=%b done=%b, required 0000/3/0/0/0",
                     wave_en, wave_sel, step_idx, busy, done);
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL async_reset_pre: %0d entries unconsumed, required 0", q.size());
            q.delete();
        end
        #2;
        tick();
        #3 rst_n = 1'b1;
        shadow_reset();
        tick();
        do_start(1, 1'b0, s);
        expect_steps(s, 1, 1'b0, 2, tl);
        drain_q();
    endtask

    initial begin
        shadow_reset();
        fork
            monitor_loop();
        join_none
        repeat (3) tick();
        test_reset();
        test_one_shot();
        test_loop_stop();
        test_busy_write();
        test_dwell_zero();
        test_single_step();
        test_stop_wrap_pend();
        test_arm_stop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
